// File: rtl/e_digit_stream.sv
// Streams the decimal expansion of an unsigned fixed-point value, most significant digit first.
// Each fraction digit comes from one truncating multiply-by-10 of the remaining fraction.
module e_digit_stream #(
  parameter int W          = 400,
  parameter int INT_BITS   = 8,
  parameter int NUM_DIGITS = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic [3:0]   digit,
  output logic         digit_valid,
  input  logic         digit_ready,
  output logic         digit_is_int,
  output logic         digit_last,
  output logic         done,
  output logic         err
);

  localparam int FW = W - INT_BITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t              state, state_n;
  logic [FW-1:0]       frac, frac_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [3:0]          digit_n;
  logic                valid_n, is_int_n, last_n, err_n;
  logic [FW+3:0]       m;
  logic [INT_BITS-1:0] int_part;

  assign int_part = value[W-1 -: INT_BITS];
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frac         <= '0;
      cnt          <= '0;
      digit        <= '0;
      digit_valid  <= 1'b0;
      digit_is_int <= 1'b0;
      digit_last   <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      frac         <= frac_n;
      cnt          <= cnt_n;
      digit        <= digit_n;
      digit_valid  <= valid_n;
      digit_is_int <= is_int_n;
      digit_last   <= last_n;
      err          <= err_n;
    end
  end

  // The top nibble of frac*10 is the next digit; the low bits are the remaining fraction.
  always_comb begin
    state_n  = state;
    frac_n   = frac;
    cnt_n    = cnt;
    digit_n  = digit;
    valid_n  = digit_valid;
    is_int_n = digit_is_int;
    last_n   = digit_last;
    err_n    = err;
    m        = ({4'b0000, frac} << 3) + ({4'b0000, frac} << 1);

    case (state)
      IDLE: begin
        if (start) begin
          frac_n = value[FW-1:0];
          cnt_n  = '0;
          err_n  = 1'b0;
          if (int_part <= INT_BITS'(9)) begin
            digit_n  = int_part[3:0];
            valid_n  = 1'b1;
            is_int_n = 1'b1;
            last_n   = (NUM_DIGITS == 1);
            state_n  = EMIT;
          end else begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end
      end
      EMIT: begin
        if (digit_valid && digit_ready) begin
          if (cnt == LAST_CNT) begin
            valid_n  = 1'b0;
            is_int_n = 1'b0;
            last_n   = 1'b0;
            state_n  = DONE;
          end else begin
            digit_n  = m[FW+3:FW];
            frac_n   = m[FW-1:0];
            cnt_n    = cnt + CW'(1);
            is_int_n = 1'b0;
            last_n   = ((cnt + CW'(1)) == LAST_CNT);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_e_digit_stream.sv
// Scoreboard bench for e_digit_stream: stimulus pushes expected digits, a negedge monitor pops and compares.
// The e input is derived from a known decimal expansion so expected digits are independent of the hex bits.
module tb_e_digit_stream;

  localparam int W  = 400;
  localparam int FW = 392;
  localparam int ND = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] value;
  logic         busy;
  logic [3:0]   digit;
  logic         digit_valid;
  logic         digit_ready;
  logic         digit_is_int;
  logic         digit_last;
  logic         done;
  logic         err;

  e_digit_stream #(.W(W), .INT_BITS(8), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .busy(busy),
    .digit(digit), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .digit_is_int(digit_is_int), .digit_last(digit_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       is_int;
    logic       last;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  logic   prev_stall = 1'b0;
  exp_t   held;

  // First 120 fractional decimal digits of e.
  string  e_frac_str = {"7182818284", "5904523536", "0287471352", "6624977572",
                        "4709369995", "9574966967", "6277240766", "3035354759",
                        "4571382178", "5251664274", "2746639193", "2003059921"};
  string  e_exp;
  string  three_five_exp;
  string  near_one_exp;
  logic [W-1:0] e_value;
  logic [W-1:0] three_five_value;
  logic [W-1:0] near_one_value;
  logic [W-1:0] err_value;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic pushString(input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.d      = 4'(s[i] - 8'd48);
      e.is_int = (i == 0);
      e.last   = (i == s.len() - 1);
      exp_q.push_back(e);
    end
  endtask

  // One-cycle start pulse; returns #1 after the edge that sampled it, scrambling value afterwards.
  task automatic applyStimulus(input logic [W-1:0] v);
    @(posedge clk);
    #1 start = 1'b1;
    value = v;
    @(posedge clk);
    #1 start = 1'b0;
    value = {13{$urandom()}};
  endtask

  task automatic waitDone(input logic exp_err);
    logic seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", 32'(seen), 1);
    checkOutput("busy_in_done", 32'(busy), 1);
    checkOutput("err_at_done", 32'(err), 32'(exp_err));
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 0);
    checkOutput("busy_after_done", 32'(busy), 0);
    checkOutput("all_digits_received", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(digit_valid), 0);
    checkOutput({tag, "_digit"}, 32'(digit), 0);
    checkOutput({tag, "_is_int"}, 32'(digit_is_int), 0);
    checkOutput({tag, "_last"}, 32'(digit_last), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Monitor: transfers are decided at the next posedge, so sample valid/ready on the negedge before it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && prev_stall) begin
      checkOutput("hold_valid", 32'(digit_valid), 1);
      checkOutput("hold_digit", 32'(digit), 32'(held.d));
      checkOutput("hold_is_int", 32'(digit_is_int), 32'(held.is_int));
      checkOutput("hold_last", 32'(digit_last), 32'(held.last));
    end
    if (!rst && digit_valid && digit_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("digit_expected", 0, 1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("digit", 32'(digit), 32'(e.d));
        checkOutput("digit_is_int", 32'(digit_is_int), 32'(e.is_int));
        checkOutput("digit_last", 32'(digit_last), 32'(e.last));
      end
    end
    prev_stall = !rst && digit_valid && !digit_ready;
    held = '{d: digit, is_int: digit_is_int, last: digit_last};
  end

  initial begin
    logic [1023:0] dec, p10, q;
    int n;

    dec = '0;
    p10 = 1024'd1;
    for (int i = 0; i < e_frac_str.len(); i++) begin
      dec = dec * 1024'd10 + 1024'(e_frac_str[i] - 8'd48);
      p10 = p10 * 1024'd10;
    end
    q = (dec << FW) / p10;
    e_value = {8'h02, q[FW-1:0]};
    e_exp = {"2", e_frac_str.substr(0, ND - 2)};

    three_five_value = {8'h03, 1'b1, 391'b0};
    three_five_exp = "35";
    for (int i = 0; i < ND - 2; i++) three_five_exp = {three_five_exp, "0"};

    near_one_value = {8'h00, {FW{1'b1}}};
    near_one_exp = "0";
    for (int i = 0; i < ND - 1; i++) near_one_exp = {near_one_exp, "9"};

    err_value = {8'h0A, 392'h1234_5678};

    rst = 1'b1;
    start = 1'b0;
    value = '0;
    digit_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkAllZero("reset");
    rst = 1'b0;
    digit_ready = 1'b1;

    $display("[TB] T1 e stream");
    pushString(e_exp);
    applyStimulus(e_value);
    checkOutput("first_digit_latency", 32'(digit_valid), 1);
    waitDone(1'b0);

    $display("[TB] T2 3.5");
    pushString(three_five_exp);
    applyStimulus(three_five_value);
    waitDone(1'b0);

    $display("[TB] T3 near one");
    pushString(near_one_exp);
    applyStimulus(near_one_value);
    waitDone(1'b0);

    $display("[TB] T4 backpressure");
    pushString(e_exp);
    applyStimulus(e_value);
    n = 0;
    for (int i = 0; i < 400 && n < ND; i++) begin
      @(negedge clk);
      if (digit_valid && digit_ready) begin
        n++;
        if (n == 1 || n == 3) begin
          @(posedge clk);
          #1 digit_ready = 1'b0;
          repeat (5) @(posedge clk);
          #1 digit_ready = 1'b1;
        end
      end
    end
    waitDone(1'b0);

    $display("[TB] T5 integer part too large");
    applyStimulus(err_value);
    checkOutput("err_no_valid", 32'(digit_valid), 0);
    waitDone(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("err_held", 32'(err), 1);
    pushString(three_five_exp);
    applyStimulus(three_five_value);
    waitDone(1'b0);

    $display("[TB] T6 ignored start and abort");
    pushString(e_exp);
    applyStimulus(e_value);
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (digit_valid && digit_ready) begin
        n++;
        if (n == 5) begin
          start = 1'b1;
          value = three_five_value;
        end
      end
    end
    start = 1'b0;
    checkOutput("abort_reached_digit10", 32'(n), 10);
    @(posedge clk);
    #1 rst = 1'b1;
    digit_ready = 1'b0;
    @(posedge clk);
    #1 checkAllZero("abort");
    rst = 1'b0;
    digit_ready = 1'b1;
    exp_q.delete();
    pushString(e_exp);
    applyStimulus(e_value);
    waitDone(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
